// File: rtl/opcode_encoder.sv
// Serializes 8-bit select vectors into 3-bit opcodes, lowest set bit first, over valid/ready.
// Build option: define OPC_ENC_STRICT_ONEHOT_EN to accept only single-bit vectors.
module opcode_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_opcode,
  output logic       out_last,
  output logic       err,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     r_state;
  logic [7:0] r_pending;
  logic [2:0] r_opcode;
  logic       r_last;
  logic       r_out_valid;
  logic       r_err;
  logic       r_busy;

  logic       w_vec_ok;
  logic       w_xfer;
  logic [7:0] w_remain;

  function automatic logic [2:0] lsb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

`ifdef OPC_ENC_STRICT_ONEHOT_EN
  assign w_vec_ok = is_onehot(in_vec);
`else
  assign w_vec_ok = (in_vec != 8'd0);
`endif

  // Handshakes: a beat moves on a rising edge where valid && ready; a raised
  // out_valid holds, with stable opcode/last, until that beat completes.
  assign w_xfer   = r_out_valid && out_ready;
  assign w_remain = r_pending & (r_pending - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pending   <= 8'd0;
      r_opcode    <= 3'd0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_vec_ok) begin
              r_state     <= EMIT;
              r_pending   <= in_vec;
              r_opcode    <= lsb_index(in_vec);
              r_last      <= is_onehot(in_vec);
              r_out_valid <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state     <= IDLE;
              r_pending   <= 8'd0;
              r_opcode    <= 3'd0;
              r_last      <= 1'b0;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              // Next opcode is precomputed from the remaining bits so it stays registered.
              r_pending <= w_remain;
              r_opcode  <= lsb_index(w_remain);
              r_last    <= is_onehot(w_remain);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // busy is the externally visible view of the state register.
  assign in_ready   = (r_state == IDLE);
  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign out_opcode = r_opcode;
  assign out_last   = r_last;
  assign err        = r_err;

endmodule

// File: tb/tb_opcode_encoder.sv
// Self-checking bench for opcode_encoder: table vectors, corner sequences, and random traffic vs a queue model.
module tb_opcode_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'd0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_opcode;
  logic       out_last;
  logic       err;
  logic       busy;

  opcode_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_last   (out_last),
    .err        (err),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];   // {last, opcode} expected, head = currently offered
  logic [2:0] got_q[$];   // opcodes seen on completed transfers
  logic       err_pend = 1'b0;
  int         err_seen = 0;
  int         valid_cycles = 0;
  bit         strict;

  typedef struct {
    logic [7:0]  vec;
    int          n;
    logic [23:0] ops;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_reject(input logic [7:0] v);
    if (v == 8'd0) return 1'b1;
    if (strict && $countones(v) != 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input logic [7:0] v);
    int left;
    left = $countones(v);
    for (int k = 0; k < 8; k++) begin
      if (v[k]) begin
        left--;
        exp_q.push_back({(left == 0), 3'(k)});
      end
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs, advance the model for the coming edge.
  task automatic step(input logic v, input logic [7:0] vec, input logic rdy, output bit accepted);
    @(negedge clk);
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
    accepted  = 1'b0;
    check1("in_ready", {7'd0, in_ready}, {7'd0, exp_q.size() == 0});
    check1("busy", {7'd0, busy}, {7'd0, exp_q.size() != 0});
    check1("out_valid", {7'd0, out_valid}, {7'd0, exp_q.size() != 0});
    check1("err", {7'd0, err}, {7'd0, err_pend});
    if (err) err_seen++;
    if (out_valid) valid_cycles++;
    if (exp_q.size() != 0) begin
      check1("out_opcode", {5'd0, out_opcode}, {5'd0, exp_q[0][2:0]});
      check1("out_last", {7'd0, out_last}, {7'd0, exp_q[0][3]});
    end
    err_pend = 1'b0;
    if (exp_q.size() != 0) begin
      if (rdy) begin
        got_q.push_back(out_opcode);
        void'(exp_q.pop_front());
      end
    end else if (v) begin
      accepted = 1'b1;
      if (model_reject(vec)) err_pend = 1'b1;
      else model_push(vec);
    end
  endtask

  task automatic idle_until_empty(input int budget);
    bit a;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_pend) && n < budget) begin
      step(1'b0, 8'd0, 1'b1, a);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d opcodes still pending after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    step(1'b0, 8'd0, 1'b1, a);
  endtask

  // ---------------- test ----------------
  initial begin
    bit         a;
    int         idx;
    int         cyc;
    logic [7:0] v;
    logic       rdy;

`ifdef OPC_ENC_STRICT_ONEHOT_EN
    strict = 1'b1;
`else
    strict = 1'b0;
`endif

    tbl[0] = '{8'h01, 1, 24'(12'o0), 1'b0};
    tbl[1] = '{8'h80, 1, 24'(12'o7), 1'b0};
    tbl[2] = '{8'h20, 1, 24'(12'o5), 1'b0};
    tbl[3] = '{8'h00, 0, 24'd0, 1'b1};
    if (strict) begin
      tbl[4] = '{8'hA5, 0, 24'd0, 1'b1};
      tbl[5] = '{8'h06, 0, 24'd0, 1'b1};
      tbl[6] = '{8'hFF, 0, 24'd0, 1'b1};
      tbl[7] = '{8'h18, 0, 24'd0, 1'b1};
    end else begin
      tbl[4] = '{8'hA5, 4, 24'(12'o7520), 1'b0};
      tbl[5] = '{8'h06, 2, 24'(12'o21), 1'b0};
      tbl[6] = '{8'hFF, 8, 24'o76543210, 1'b0};
      tbl[7] = '{8'h18, 2, 24'(12'o43), 1'b0};
    end

    // reset state
    #12;
    check1("rst out_valid", {7'd0, out_valid}, 8'd0);
    check1("rst in_ready", {7'd0, in_ready}, 8'd1);
    check1("rst busy", {7'd0, busy}, 8'd0);
    check1("rst err", {7'd0, err}, 8'd0);
    check1("rst out_opcode", {5'd0, out_opcode}, 8'd0);
    check1("rst out_last", {7'd0, out_last}, 8'd0);
    #1 rst_n = 1'b1;

    // table vectors, consumer always ready
    for (int t = 0; t < 8; t++) begin
      got_q.delete();
      err_seen = 0;
      step(1'b1, tbl[t].vec, 1'b1, a);
      idle_until_empty(20);
      check1("tbl count", 8'(got_q.size()), 8'(tbl[t].n));
      for (int i = 0; i < tbl[t].n && i < got_q.size(); i++)
        check1("tbl opcode", {5'd0, got_q[i]}, {5'd0, tbl[t].ops[3*i +: 3]});
      check1("tbl err", 8'(err_seen), {7'd0, tbl[t].exp_err});
    end

    // one-hot with backpressure; a different vector offered while busy is ignored
    got_q.delete();
    valid_cycles = 0;
    step(1'b1, 8'h20, 1'b0, a);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h03, 1'b0, a);
    step(1'b0, 8'h00, 1'b1, a);
    step(1'b0, 8'h00, 1'b1, a);
    check1("bp valid cycles", 8'(valid_cycles), 8'd4);
    check1("bp transfers", 8'(got_q.size()), 8'd1);
    if (got_q.size() != 0) check1("bp opcode", {5'd0, got_q[0]}, 8'd5);

    // back-to-back one-hot sweep, in_valid held high throughout
    got_q.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 8 || exp_q.size() != 0) && cyc < 40) begin
      v = (idx < 8) ? (8'd1 << idx) : 8'd0;
      step(idx < 8, v, 1'b1, a);
      if (a) idx++;
      cyc++;
    end
    check1("sweep cycles", 8'(cyc), 8'd16);
    check1("sweep count", 8'(got_q.size()), 8'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check1("sweep opcode", {5'd0, got_q[i]}, 8'(i));
    idle_until_empty(4);

    // asynchronous reset while the first opcode of 8'h06 is stalled
    step(1'b1, 8'h06, 1'b0, a);
    step(1'b0, 8'h00, 1'b0, a);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check1("arst out_valid", {7'd0, out_valid}, 8'd0);
    check1("arst in_ready", {7'd0, in_ready}, 8'd1);
    check1("arst busy", {7'd0, busy}, 8'd0);
    check1("arst out_opcode", {5'd0, out_opcode}, 8'd0);
    exp_q.delete();
    err_pend = 1'b0;
    #4 rst_n = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, a);
    check1("arst no output", 8'(valid_cycles), 8'd0);

    // randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'd0;
        1:       v = 8'd1 << $urandom_range(0, 7);
        default: v = 8'($urandom_range(0, 255));
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), v, rdy, a);
    end
    idle_until_empty(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opcode_encoder.md
Name: opcode_encoder

Overview:
- Inverse of the opcode decode path: converts 8-bit one-hot or multi-hot select vectors back into 3-bit opcodes.
- Sits between control-unit request lines (e.g. a sequencer's strobe bank) and any consumer that accepts a compact opcode stream.
- Each accepted vector is serialized into one opcode per set bit, lowest index first.
- Valid/ready handshake on both sides; registered outputs.

Parameters:
- none; widths fixed at 8-bit vector and 3-bit opcode, matching the decoder's opcode space.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  8  select vector; bit k corresponds to opcode k
- out_valid  output  1  out_opcode is valid
- out_ready  input  1  consumer accepts out_opcode
- out_opcode  output  3  encoded opcode
- out_last  output  1  current opcode is the final one for this vector
- err  output  1  one-cycle pulse for a rejected vector
- busy  output  1  vector in progress, i.e. state is EMIT

Behaviour:
- Reset
  - One clock, async active-low reset: clk, rst_n.
  - rst_n low immediately forces state=IDLE, pending=0, out_valid=0, out_opcode=0, out_last=0, err=0, busy=0, in_ready=1.
  - Asserting reset mid-vector discards the remaining opcodes; no partial output follows deassertion.
- States: IDLE, EMIT.
- IDLE
  - in_ready=1, out_valid=0.
  - When in_valid is sampled high:
    - in_vec==0: vector consumed, no output, err=1 next cycle, stay IDLE.
    - otherwise: pending<=in_vec, go to EMIT.
- EMIT
  - in_ready=0, busy=1, out_valid=1.
  - out_opcode = index of lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
- Transfer
  - A transfer occurs on a cycle with out_valid && out_ready.
  - On transfer: clear that bit in pending.
  - If out_last: go to IDLE; in_ready reasserts the following cycle. There is no same-cycle accept on the last transfer.
- Stall: while out_ready=0, out_opcode, out_last and pending hold stable. out_valid never drops without a transfer.
- Latency: vector accepted in cycle N gives first out_valid in cycle N+1.
- Throughput: one opcode per cycle while out_ready is high. A single-bit vector costs 2 cycles (accept + emit).
- Registers: all outputs are registered; in_ready is derived from state only (registered state decode).
- err: a single-cycle pulse, never sticky. in_vec is ignored outside IDLE.
- Encoding order: strictly ascending bit index. Bit 7 alone yields opcode 7 with out_last=1.

Optional Feature:
- Macro: OPC_ENC_STRICT_ONEHOT_EN.
- Defined: only vectors with exactly one bit set are encoded.
  - Multi-hot vectors are consumed in IDLE, produce no output, and pulse err=1 next cycle, like zero vectors.
  - out_last is always 1 whenever out_valid=1.
- Undefined: multi-hot vectors are serialized as above; err pulses only for zero vectors.

Test Plan:
- Reset mid-EMIT
  - Stimulus: in_vec=8'h06 accepted, first opcode held stalled, rst_n pulsed low asynchronously (not clock-aligned).
  - Required: out_valid drops immediately, in_ready=1 after release, no opcode 1 or 2 emitted afterward.
- One-hot with backpressure
  - Stimulus: in_vec=8'h20, out_ready=0 for 3 cycles then 1.
  - Required: out_opcode=5, out_last=1 held stable 4 cycles; single transfer; in_ready=1 the cycle after.
- Multi-hot, macro undefined
  - Stimulus: in_vec=8'hA5, out_ready=1.
  - Required: opcodes 0,2,5,7 on consecutive cycles; out_last only on 7; err never asserted.
- Multi-hot, macro defined
  - Stimulus: in_vec=8'hA5.
  - Required: no out_valid, err=1 for exactly one cycle, in_ready stays 1.
- Zero vector
  - Stimulus: in_vec=8'h00 with in_valid=1.
  - Required: err=1 one cycle, out_valid=0, state remains IDLE.
- Back-to-back sweep
  - Stimulus: vectors 8'h01,8'h02,...,8'h80 offered continuously.
  - Required: opcodes 0..7 in order, each with out_last=1, one vector every 2 cycles; in_vec ignored while busy=1.
